// File: rtl/cmpl_prod_requant_pkg.sv
// Shared widths and helpers for the complex-product requantiser.
package cmpl_prod_requant_pkg;

    localparam int unsigned FFT_PROD_W = 36;
    localparam int unsigned FFT_SMP_W  = 18;
    localparam int unsigned SHIFT_W    = 6;

    // Largest useful right shift for a 36-bit product.
    localparam logic [SHIFT_W-1:0] SHIFT_MAX = 6'd35;

    function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] sh);
        return (sh > SHIFT_MAX) ? SHIFT_MAX : sh;
    endfunction

endpackage

// File: rtl/cmpl_prod_requant_if.sv
// Product input strobe plus requantised-sample valid/ready output, bundled as one bus.
interface cmpl_prod_requant_if
    import cmpl_prod_requant_pkg::*;
#(
    parameter int unsigned IN_W  = FFT_PROD_W,
    parameter int unsigned OUT_W = FFT_SMP_W
);

    logic               in_valid;
    logic [IN_W-1:0]    in_real;
    logic [IN_W-1:0]    in_imag;
    logic [SHIFT_W-1:0] shift_cfg;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W-1:0]   out_real;
    logic [OUT_W-1:0]   out_imag;
    logic               out_sat;

    // Producer of products / consumer of samples.
    modport master (
        output in_valid, in_real, in_imag, shift_cfg, out_ready,
        input  out_valid, out_real, out_imag, out_sat
    );

    // The requantiser itself.
    modport slave (
        input  in_valid, in_real, in_imag, shift_cfg, out_ready,
        output out_valid, out_real, out_imag, out_sat
    );

endinterface

// File: rtl/cmpl_fifo_fwft.sv
// First-word fall-through FIFO; head entry is visible on rd_data_o whenever not empty.
module cmpl_fifo_fwft
    import cmpl_prod_requant_pkg::*;
#(
    parameter int unsigned WIDTH = 2 * FFT_SMP_W + 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_wr, do_rd;

    assign empty_o   = (level_q == '0);
    assign full_o    = (level_q == LVL_FULL);
    assign level_o   = level_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // A write into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_rd = rd_en_i & ~empty_o;
    assign do_wr = wr_en_i & (~full_o | do_rd);

    // Pointer and occupancy next state; pointers wrap naturally as DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({do_wr, do_rd})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Control state, flushed asynchronously by reset.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is not reset; stale entries are never visible because level gates validity.
    always_ff @(posedge clock) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/cmpl_prod_requant.sv
// Rounds, shifts and saturates complex products, then buffers them for the next stage.
module cmpl_prod_requant
    import cmpl_prod_requant_pkg::*;
#(
    parameter int unsigned IN_W  = FFT_PROD_W,
    parameter int unsigned OUT_W = FFT_SMP_W,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   rst_n,
    cmpl_prod_requant_if.slave     bus_if,
    input  logic                   clr_stats_i,
    output logic [$clog2(DEPTH):0] fifo_level_o,
    output logic [CNT_W-1:0]       sat_cnt_o,
    output logic                   ovf_sticky_o
);

    localparam int unsigned FIFO_W = 2 * OUT_W + 1;

    localparam logic signed [IN_W:0] RND_ONE = {{IN_W{1'b0}}, 1'b1};
    localparam logic signed [IN_W:0] SAT_MAX = {{(IN_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [IN_W:0] SAT_MIN = {{(IN_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

    // Returns {clamped_flag, OUT_W-bit value}.
    function automatic logic [OUT_W:0] saturate(input logic signed [IN_W:0] v);
        if (v > SAT_MAX)      return {1'b1, SAT_MAX[OUT_W-1:0]};
        else if (v < SAT_MIN) return {1'b1, SAT_MIN[OUT_W-1:0]};
        else                  return {1'b0, v[OUT_W-1:0]};
    endfunction

    logic [SHIFT_W-1:0]    shift;
    logic signed [IN_W:0]  rnd, re_sum, im_sum;
    logic signed [IN_W:0]  s1_re_d, s1_im_d, s1_re_q, s1_im_q;
    logic                  s1_valid_q;
    logic [OUT_W:0]        re_sat, im_sat;
    logic [FIFO_W-1:0]     s2_data_d, s2_data_q;
    logic                  s2_valid_q;

    logic                  fifo_empty, fifo_full, pop, wr_ok, drop;
    logic [FIFO_W-1:0]     head;
    logic [CNT_W-1:0]      sat_cnt_q, sat_cnt_d;
    logic                  ovf_q, ovf_d;

    // Stage 1: add half an LSB of the shifted result, then arithmetic shift.
    always_comb begin
        shift   = clamp_shift(bus_if.shift_cfg);
        rnd     = (shift == '0) ? '0 : (RND_ONE << (shift - 6'd1));
        re_sum  = $signed({bus_if.in_real[IN_W-1], bus_if.in_real}) + rnd;
        im_sum  = $signed({bus_if.in_imag[IN_W-1], bus_if.in_imag}) + rnd;
        s1_re_d = re_sum >>> shift;
        s1_im_d = im_sum >>> shift;
    end

    // Stage 2: clamp both components and tag the sample if either clipped.
    always_comb begin
        re_sat    = saturate(s1_re_q);
        im_sat    = saturate(s1_im_q);
        s2_data_d = {re_sat[OUT_W] | im_sat[OUT_W], re_sat[OUT_W-1:0], im_sat[OUT_W-1:0]};
    end

    // Free-running two-stage pipeline; never stalls on out_ready.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_re_q    <= '0;
            s1_im_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            s1_valid_q <= bus_if.in_valid;
            s1_re_q    <= s1_re_d;
            s1_im_q    <= s1_im_d;
            s2_valid_q <= s1_valid_q;
            s2_data_q  <= s2_data_d;
        end
    end

    assign pop   = ~fifo_empty & bus_if.out_ready;
    assign wr_ok = s2_valid_q & (~fifo_full | pop);
    assign drop  = s2_valid_q & fifo_full & ~pop;

    cmpl_fifo_fwft #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .rst_n     (rst_n),
        .wr_en_i   (s2_valid_q),
        .wr_data_i (s2_data_q),
        .rd_en_i   (pop),
        .rd_data_o (head),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full),
        .level_o   (fifo_level_o)
    );

    // Head fields are forced to zero while empty so nothing stale leaks out.
    always_comb begin
        bus_if.out_valid = ~fifo_empty;
        bus_if.out_sat   = fifo_empty ? 1'b0 : head[FIFO_W-1];
        bus_if.out_real  = fifo_empty ? '0 : head[2*OUT_W-1:OUT_W];
        bus_if.out_imag  = fifo_empty ? '0 : head[OUT_W-1:0];
    end

    // Statistics next state; clear beats any same-cycle event.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        ovf_d     = ovf_q;
        if (clr_stats_i) begin
            sat_cnt_d = '0;
            ovf_d     = 1'b0;
        end else begin
            if (wr_ok && s2_data_q[FIFO_W-1] && (sat_cnt_q != '1)) sat_cnt_d = sat_cnt_q + 1'b1;
            if (drop) ovf_d = 1'b1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
            ovf_q     <= ovf_d;
        end
    end

    assign sat_cnt_o    = sat_cnt_q;
    assign ovf_sticky_o = ovf_q;

endmodule

// File: tb/tb_cmpl_prod_requant.sv
// Directed bench for the complex-product requantiser.
module tb_cmpl_prod_requant;

    localparam int unsigned IN_W  = 36;
    localparam int unsigned OUT_W = 18;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 16;

    logic             clock = 1'b0;
    logic             rst_n;
    logic             clr_stats;
    logic [2:0]       fifo_level;
    logic [CNT_W-1:0] sat_cnt;
    logic             ovf_sticky;

    int checks = 0;
    int errors = 0;

    cmpl_prod_requant_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    cmpl_prod_requant #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clock        (clock),
        .rst_n        (rst_n),
        .bus_if       (bus),
        .clr_stats_i  (clr_stats),
        .fifo_level_o (fifo_level),
        .sat_cnt_o    (sat_cnt),
        .ovf_sticky_o (ovf_sticky)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [35:0] re, input logic [35:0] im,
                         input logic [5:0] sh);
        bus.in_valid  = v;
        bus.in_real   = re;
        bus.in_imag   = im;
        bus.shift_cfg = sh;
    endtask

    // One product strobe, sampled at the next edge.
    task automatic send(input logic [35:0] re, input logic [35:0] im, input logic [5:0] sh);
        drive(1'b1, re, im, sh);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clr_stats = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, '0, '0, '0);
        #12;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out_real !== 18'h0) begin errors++; $display("FAIL rst_out_real got %h want 0", bus.out_real); end
        checks++; if (bus.out_imag !== 18'h0) begin errors++; $display("FAIL rst_out_imag got %h want 0", bus.out_imag); end
        checks++; if (bus.out_sat !== 1'b0) begin errors++; $display("FAIL rst_out_sat got %b want 0", bus.out_sat); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level got %0d want 0", fifo_level); end
        checks++; if (sat_cnt !== 16'd0) begin errors++; $display("FAIL rst_sat_cnt got %0d want 0", sat_cnt); end
        checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", ovf_sticky); end
        @(negedge clock);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_scaling();
        bus.out_ready = 1'b1;
        send(36'h0_4000_0000, 36'h0, 6'd17);
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL scale_early_valid got %b want 0", bus.out_valid); end
        tick();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL scale_valid got %b want 1", bus.out_valid); end
        checks++; if (bus.out_real !== 18'h02000) begin errors++; $display("FAIL scale_real got %h want 02000", bus.out_real); end
        checks++; if (bus.out_imag !== 18'h0) begin errors++; $display("FAIL scale_imag got %h want 0", bus.out_imag); end
        checks++; if (bus.out_sat !== 1'b0) begin errors++; $display("FAIL scale_sat got %b want 0", bus.out_sat); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL scale_pop got %b want 0", bus.out_valid); end
    endtask

    task automatic test_rounding();
        logic [35:0] re_tab [3];
        logic [5:0]  sh_tab [3];
        logic [17:0] exp_tab [3];
        re_tab  = '{36'd196608, 36'hF_FFFD_0000, 36'd5};
        sh_tab  = '{6'd17, 6'd17, 6'd0};
        exp_tab = '{18'd2, 18'h3FFFF, 18'd5};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(re_tab[i], 36'h0, sh_tab[i]);
            tick();
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_real !== exp_tab[i]) begin
                errors++;
                $display("FAIL round_%0d got valid=%b real=%h want valid=1 real=%h",
                         i, bus.out_valid, bus.out_real, exp_tab[i]);
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        bus.out_ready = 1'b1;
        send(36'h4_0000_0000, 36'h0, 6'd17);
        tick();
        tick();
        checks++; if (bus.out_real !== 18'h1FFFF) begin errors++; $display("FAIL sat_pos_real got %h want 1FFFF", bus.out_real); end
        checks++; if (bus.out_sat !== 1'b1) begin errors++; $display("FAIL sat_pos_flag got %b want 1", bus.out_sat); end
        checks++; if (sat_cnt !== 16'd1) begin errors++; $display("FAIL sat_cnt_1 got %0d want 1", sat_cnt); end
        tick();
        send(36'h0, 36'h8_0000_0000, 6'd17);
        tick();
        tick();
        checks++; if (bus.out_imag !== 18'h20000) begin errors++; $display("FAIL sat_neg_imag got %h want 20000", bus.out_imag); end
        checks++; if (sat_cnt !== 16'd2) begin errors++; $display("FAIL sat_cnt_2 got %0d want 2", sat_cnt); end
        tick();
        // Clear lands on the same edge that writes the next saturated sample.
        send(36'h4_0000_0000, 36'h0, 6'd17);
        tick();
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        checks++; if (sat_cnt !== 16'd0) begin errors++; $display("FAIL sat_clr_prio got %0d want 0", sat_cnt); end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_sat !== 1'b1) begin errors++; $display("FAIL sat_clr_sample got valid=%b sat=%b want 1 1", bus.out_valid, bus.out_sat); end
        tick();
    endtask

    task automatic test_overflow();
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 36'(i), 36'h0, 6'd0);
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        tick();
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d want 4", fifo_level); end
        checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", ovf_sticky); end
        checks++; if (sat_cnt !== 16'd0) begin errors++; $display("FAIL ovf_sat_cnt got %0d want 0", sat_cnt); end
        tick();
        checks++; if (bus.out_real !== 18'd1) begin errors++; $display("FAIL ovf_hold got %h want 1", bus.out_real); end
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_real !== 18'(k)) begin
                errors++;
                $display("FAIL ovf_drain_%0d got valid=%b real=%h want valid=1 real=%h",
                         k, bus.out_valid, bus.out_real, 18'(k));
            end
            tick();
        end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b want 0", bus.out_valid); end
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b want 0", ovf_sticky); end
    endtask

    task automatic test_full_pop();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 36'(31 + i), 36'h0, 6'd0);
            tick();
        end
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL full_fill got %0d want 4", fifo_level); end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 36'(37 + k), 36'h0, 6'd0);
            tick();
            checks++;
            if (fifo_level !== 3'd4 || bus.out_real !== 18'(32 + k) || ovf_sticky !== 1'b0) begin
                errors++;
                $display("FAIL full_pop_%0d got level=%0d real=%0d ovf=%b want 4 %0d 0",
                         k, fifo_level, bus.out_real, ovf_sticky, 32 + k);
            end
        end
        bus.in_valid = 1'b0;
        repeat (8) tick();
        checks++; if (bus.out_valid !== 1'b0 || fifo_level !== 3'd0) begin errors++; $display("FAIL full_drain got valid=%b level=%0d want 0 0", bus.out_valid, fifo_level); end
        checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL full_no_drop got %b want 0", ovf_sticky); end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 36'(41 + i), 36'h0, 6'd0);
            tick();
        end
        bus.in_valid = 1'b0;
        checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL mid_level got %0d want 3", fifo_level); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", bus.out_valid); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL mid_flush got %0d want 0", fifo_level); end
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        send(36'd50, 36'h0, 6'd0);
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_early got %b want 0", bus.out_valid); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_real !== 18'd50) begin errors++; $display("FAIL mid_first got valid=%b real=%0d want 1 50", bus.out_valid, bus.out_real); end
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL mid_discard got %0d want 1", fifo_level); end
        tick();
    endtask

    initial begin
        test_reset();
        test_scaling();
        test_rounding();
        test_saturation();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmpl_prod_requant.md
Name: cmpl_prod_requant

Overview:
- Consumer end of the complex-multiplier product interface in the FFT datapath.
- Accepts 36-bit real/imag products tagged by a valid strobe and shifts them right by a programmable amount with round-half-up.
- Saturates the results to 18 bits and buffers them in a small FIFO.
- Presents the FIFO contents on a valid/ready interface to the next butterfly stage or the output writer.
- Tracks saturation and overflow statistics.

Parameters:
IN_W, 36, product width (real and imag each)
OUT_W, 18, output sample width
DEPTH, 4, FIFO entries (power of two, >=2)
CNT_W, 16, saturation counter width

Ports:
clock  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  product valid strobe (no upstream backpressure)
in_real  in  IN_W  signed real product
in_imag  in  IN_W  signed imag product
shift_cfg  in  6  right-shift amount, sampled with in_valid
out_valid  out  1  FIFO head valid
out_ready  in  1  downstream accept
out_real  out  OUT_W  signed requantised real
out_imag  out  OUT_W  signed requantised imag
out_sat  out  1  head sample had real or imag saturated
fifo_level  out  log2(DEPTH)+1  current occupancy
sat_cnt  out  CNT_W  count of saturated samples accepted into FIFO
ovf_sticky  out  1  a sample was dropped because the FIFO was full
clr_stats  in  1  synchronous clear of sat_cnt and ovf_sticky

Behaviour:
- Interface: one clock "clock"; reset is asynchronous and active-low on "rst_n". All registers use non-blocking assignment with the SIM_DLY delay from fft_inc.h.
- Reset values: out_valid=0, out_real=0, out_imag=0, out_sat=0, fifo_level=0, sat_cnt=0, ovf_sticky=0. All pipeline valid bits=0 and FIFO pointers=0.
- Stage 1 (round), registered:
  - Clamp shift_cfg to 35 when it is greater than 35. Call the result s.
  - If s>0: sum = sign-extended (IN_W+1)-bit input + (1<<(s-1)). If s=0: no add.
  - Arithmetic shift the sum right by s.
  - Valid and shifted values are registered.
- Stage 2 (saturate), registered:
  - Clamp each component to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - sat = real clamped OR imag clamped. sat is stored with the sample.
- FIFO write:
  - Occurs on the edge after stage 2 holds valid data.
  - Timing: in_valid sampled at edge N is written at edge N+2. With an empty FIFO, out_valid=1 after edge N+2 (first-word fall-through).
- Pop: happens at an edge where out_valid=1 and out_ready=1. out_* values are stable while out_valid=1 and out_ready=0.
- Full FIFO:
  - A write with no pop in the same cycle drops the sample and sets ovf_sticky=1. sat_cnt is not incremented.
  - A write with a simultaneous pop is accepted; fifo_level is unchanged.
- Empty FIFO with a write: out_valid rises the following cycle. A same-cycle bypass of write data to the head is not allowed.
- Pipeline: stages 1-2 never stall and run every cycle regardless of out_ready.
- sat_cnt:
  - Increments by 1 per accepted saturated sample.
  - Holds at all-ones; no wrap.
- clr_stats:
  - Clears sat_cnt and ovf_sticky at the next edge.
  - Clear takes priority over a same-cycle increment or overflow event; the result is 0.
- Pointers wrap modulo DEPTH. fifo_level ranges from 0 to DEPTH.
- Reset mid-operation:
  - Flushes the pipeline and FIFO immediately and asynchronously.
  - Samples in flight are discarded.
  - out_valid goes to 0 without waiting for a clock edge.

Decomposition:
- fft_inc.h: SIM_DLY, plus shared defines FFT_PROD_W=36 and FFT_SMP_W=18, which are used as parameter defaults.
- Sub-module cmpl_fifo_fwft holds the FIFO.
  - Parameters: width, DEPTH. Each entry is {sat, real, imag}, width 2*OUT_W+1.
  - Ports: clock, rst_n, wr_en, wr_data, rd_en, rd_data, empty, full, level.
- Rounding and saturation stay in the top level.

Test Plan:
- Scaling: in_real=36'h0_4000_0000, in_imag=0, shift_cfg=17, out_ready=1 -> out_real=18'h02000, out_imag=0, out_sat=0, out_valid high after edge N+2.
- Rounding:
  - in_real=196608 (1.5 after shift 17) -> out_real=2.
  - in_real=-196608 -> out_real=-1 (18'h3FFFF).
  - shift_cfg=0 with in_real=5 -> out_real=5.
- Saturation:
  - in_real=2^34, shift 17 -> out_real=18'h1FFFF, out_sat=1, sat_cnt=1.
  - in_imag=-2^35, shift 17 -> out_imag=18'h20000, sat_cnt=2.
  - Then clr_stats=1 together with another saturated sample -> sat_cnt=0.
- Backpressure/overflow:
  - out_ready=0 and 6 consecutive in_valid samples (values 1..6, shift 0) -> fifo_level=4, ovf_sticky=1.
  - Then out_ready=1 -> out_real sequence 1,2,3,4, then out_valid=0.
- Full with simultaneous pop: FIFO full, out_ready=1, continuous in_valid -> no drop, fifo_level stays 4, ovf_sticky stays 0.
- Reset mid-stream: assert rst_n=0 between edges with FIFO at level 3 -> out_valid=0, fifo_level=0 immediately. After release, the first new sample emerges 2 edges after it is sampled.
